// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix-operation blocks (loader, det_4x4, ...).
// Grid element (r,c) lives at index r*4+c, packed MSB-first into a 128-bit word.
package matrix_pkg;
   localparam int DATA_W  = 8;
   localparam int MAX_DIM = 4;
   localparam int PACK_W  = MAX_DIM * MAX_DIM * DATA_W;

   localparam logic [1:0] SIZE_2X2 = 2'b00;
   localparam logic [1:0] SIZE_3X3 = 2'b01;
   localparam logic [1:0] SIZE_4X4 = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_HOLD = 2'd2
   } loader_state_t;

   // Bit offset of grid element (row,col): (15 - (row*4+col)) * 8.
   function automatic logic [6:0] pack_index(input logic [1:0] row, input logic [1:0] col);
      logic [3:0] idx;
      idx = {row, col};
      return {4'd15 - idx, 3'b000};
   endfunction
endpackage

// File: rtl/matrix_index_counter.sv
// Row-major row/col walker over an n x n block; last flags element (n-1,n-1).
module matrix_index_counter
   import matrix_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clear,
   input  logic       inc,
   input  logic [2:0] dim,
   output logic [1:0] row,
   output logic [1:0] col,
   output logic       last
);
   logic col_end;

   assign col_end = ({1'b0, col} == dim - 3'd1);
   assign last    = col_end && ({1'b0, row} == dim - 3'd1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row <= 2'd0;
         col <= 2'd0;
      end else if (clear) begin
         row <= 2'd0;
         col <= 2'd0;
      end else if (inc) begin
         // Wrapping after the last element keeps the index inside n*n-1.
         if (last) begin
            row <= 2'd0;
            col <= 2'd0;
         end else if (col_end) begin
            row <= row + 2'd1;
            col <= 2'd0;
         end else begin
            col <= col + 2'd1;
         end
      end
   end
endmodule

// File: rtl/matrix_loader.sv
// Collects a 2x2/3x3/4x4 signed matrix element-by-element (row-major) and
// presents it packed on a valid/ready output, frozen until accepted.
module matrix_loader
   import matrix_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [1:0]          size,
   input  logic                abort,
   input  logic [DATA_W-1:0]   in_data,
   input  logic                in_valid,
   output logic                in_ready,
   output logic [PACK_W-1:0]   A,
   output logic                a_valid,
   input  logic                a_ready,
   output logic                busy,
   output logic                err
);
   // Handshakes: a transfer happens on a rising edge where valid and ready
   // are both high; ready/valid are registered and abort overrides both.
   localparam logic [1:0] S_IDLE = ST_IDLE;
   localparam logic [1:0] S_LOAD = ST_LOAD;
   localparam logic [1:0] S_HOLD = ST_HOLD;

   logic [1:0] state;
   logic [2:0] n;
   logic [1:0] row;
   logic [1:0] col;
   logic       last;
   logic       cnt_clear;
   logic       cnt_inc;
   logic [2:0] n_next;

   always_comb begin
      n_next = 3'd4;
      case (size)
         SIZE_2X2: n_next = 3'd2;
         SIZE_3X3: n_next = 3'd3;
         default:  n_next = 3'd4;
      endcase
   end

   assign cnt_clear = abort || ((state == S_IDLE) && start);
   assign cnt_inc   = !abort && (state == S_LOAD) && in_valid && in_ready;

   matrix_index_counter u_counter (
      .clk   (clk),
      .rst   (rst),
      .clear (cnt_clear),
      .inc   (cnt_inc),
      .dim   (n),
      .row   (row),
      .col   (col),
      .last  (last)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         n        <= 3'd4;
         A        <= '0;
         a_valid  <= 1'b0;
         in_ready <= 1'b0;
         busy     <= 1'b0;
         err      <= 1'b0;
      end else begin
         err <= 1'b0;
         if (abort) begin
            state    <= S_IDLE;
            A        <= '0;
            a_valid  <= 1'b0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (start) begin
                     if (size == 2'b11) begin
                        err <= 1'b1;
                     end else begin
                        n        <= n_next;
                        A        <= '0;
                        state    <= S_LOAD;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                     end
                  end
               end
               S_LOAD: begin
                  if (in_valid && in_ready) begin
                     A[pack_index(row, col) +: DATA_W] <= in_data;
                     if (last) begin
                        state    <= S_HOLD;
                        in_ready <= 1'b0;
                        a_valid  <= 1'b1;
                     end
                  end
               end
               S_HOLD: begin
                  if (a_ready) begin
                     state   <= S_IDLE;
                     a_valid <= 1'b0;
                     busy    <= 1'b0;
                  end
               end
               default: begin
                  state    <= S_IDLE;
                  a_valid  <= 1'b0;
                  in_ready <= 1'b0;
                  busy     <= 1'b0;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_matrix_loader.sv
// Directed bench for matrix_loader with hand-computed packed matrices.
module tb_matrix_loader;
   import matrix_pkg::*;

   logic               clk = 1'b0;
   logic               rst;
   logic               start;
   logic [1:0]         size;
   logic               abort;
   logic [DATA_W-1:0]  in_data;
   logic               in_valid;
   logic               in_ready;
   logic [PACK_W-1:0]  A;
   logic               a_valid;
   logic               a_ready;
   logic               busy;
   logic               err;

   int total = 0;
   int bad   = 0;

   matrix_loader dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .size     (size),
      .abort    (abort),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .A        (A),
      .a_valid  (a_valid),
      .a_ready  (a_ready),
      .busy     (busy),
      .err      (err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [PACK_W-1:0] got, input logic [PACK_W-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h want=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [1:0] sz);
      start = 1'b1;
      size  = sz;
      tick();
      start = 1'b0;
   endtask

   task automatic send(input logic [7:0] d, input int gap);
      in_data  = d;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      in_data  = 8'hee;
      repeat (gap) tick();
   endtask

   localparam logic [127:0] IDENT4 = 128'h01000000_00010000_00000100_00000001;
   localparam logic [127:0] MAT2   = 128'h01020000_03040000_00000000_00000000;
   localparam logic [127:0] MAT3   = 128'h01020300_04050600_07080900_00000000;
   localparam logic [127:0] SEQ16  = 128'h01020304_05060708_090a0b0c_0d0e0f10;

   initial begin
      rst = 1'b1; start = 1'b0; size = 2'b00; abort = 1'b0;
      in_data = 8'h00; in_valid = 1'b0; a_ready = 1'b0;
      #1;
      check("rst_A", A, '0);
      check("rst_a_valid", {127'd0, a_valid}, 128'd0);
      check("rst_in_ready", {127'd0, in_ready}, 128'd0);
      check("rst_busy", {127'd0, busy}, 128'd0);
      check("rst_err", {127'd0, err}, 128'd0);
      repeat (2) tick();
      rst = 1'b0;
      tick();

      // 4x4 identity, in_valid continuously high
      do_start(2'b10);
      check("id_busy", {127'd0, busy}, 128'd1);
      check("id_in_ready", {127'd0, in_ready}, 128'd1);
      for (int i = 0; i < 16; i++) begin
         in_data  = (i % 5 == 0) ? 8'h01 : 8'h00;
         in_valid = 1'b1;
         tick();
         if (i == 14) check("id_no_early_valid", {127'd0, a_valid}, 128'd0);
      end
      in_valid = 1'b0;
      check("id_a_valid", {127'd0, a_valid}, 128'd1);
      check("id_in_ready_off", {127'd0, in_ready}, 128'd0);
      check("id_A", A, IDENT4);
      a_ready = 1'b1;
      tick();
      a_ready = 1'b0;
      check("id_done_valid", {127'd0, a_valid}, 128'd0);
      check("id_done_busy", {127'd0, busy}, 128'd0);
      check("id_A_retained", A, IDENT4);

      // 2x2; a size change mid-load must be ignored
      do_start(2'b00);
      check("m2_A_cleared", A, '0);
      size = 2'b10;
      send(8'h01, 0); send(8'h02, 0); send(8'h03, 0);
      check("m2_not_yet", {127'd0, a_valid}, 128'd0);
      send(8'h04, 0);
      check("m2_a_valid", {127'd0, a_valid}, 128'd1);
      check("m2_A", A, MAT2);
      send(8'h77, 0);
      check("m2_hold_ignores_input", A, MAT2);
      a_ready = 1'b1;
      tick();
      a_ready = 1'b0;
      check("m2_idle", {127'd0, busy}, 128'd0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("idle_abort_clears_A", A, '0);

      // 3x3 with 2-cycle gaps and a slow consumer
      do_start(2'b01);
      for (int i = 1; i <= 9; i++) begin
         send(i[7:0], (i == 9) ? 0 : 2);
         if (i == 5) check("m3_ready_in_gap", {127'd0, in_ready}, 128'd1);
      end
      for (int k = 0; k < 5; k++) begin
         check("m3_hold_valid", {127'd0, a_valid}, 128'd1);
         check("m3_hold_A", A, MAT3);
         tick();
      end
      a_ready = 1'b1;
      tick();
      a_ready = 1'b0;
      check("m3_done_busy", {127'd0, busy}, 128'd0);
      check("m3_done_valid", {127'd0, a_valid}, 128'd0);

      // illegal size
      do_start(2'b11);
      check("ill_err", {127'd0, err}, 128'd1);
      check("ill_busy", {127'd0, busy}, 128'd0);
      check("ill_in_ready", {127'd0, in_ready}, 128'd0);
      check("ill_A_kept", A, MAT3);
      tick();
      check("ill_err_pulse", {127'd0, err}, 128'd0);

      // abort after 7 of 16, then a clean reload
      do_start(2'b10);
      for (int i = 1; i <= 7; i++) send(i[7:0], 0);
      abort = 1'b1;
      in_valid = 1'b1;
      in_data = 8'h55;
      tick();
      abort = 1'b0;
      in_valid = 1'b0;
      check("ab_A", A, '0);
      check("ab_in_ready", {127'd0, in_ready}, 128'd0);
      check("ab_busy", {127'd0, busy}, 128'd0);
      check("ab_a_valid", {127'd0, a_valid}, 128'd0);
      do_start(2'b10);
      for (int i = 1; i <= 16; i++) send(i[7:0], 0);
      check("re_a_valid", {127'd0, a_valid}, 128'd1);
      check("re_A", A, SEQ16);
      a_ready = 1'b1;
      tick();
      a_ready = 1'b0;

      // async reset while holding a valid matrix
      do_start(2'b00);
      send(8'hff, 0); send(8'h80, 0); send(8'h7f, 0); send(8'h01, 0);
      check("ar_pre_valid", {127'd0, a_valid}, 128'd1);
      check("ar_pre_A", A, 128'hff800000_7f010000_00000000_00000000);
      #2;
      rst = 1'b1;
      #1;
      check("ar_a_valid", {127'd0, a_valid}, 128'd0);
      check("ar_A", A, '0);
      check("ar_busy", {127'd0, busy}, 128'd0);
      tick();
      rst = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/matrix_loader.md
Name: matrix_loader

Overview:
- Upstream feeder for det_4x4 and the other matrix-operation blocks.
- Accepts signed 8-bit elements one per handshake, row-major, for a 2x2, 3x3 or 4x4 matrix.
- Places each element in the packed 128-bit 4x4 layout: element index i occupies A[(15-i)*8 +: 8].
- Presents the completed matrix on a valid/ready output and holds it stable until the consumer accepts it.

Parameters:
- DATA_W, 8, element width in bits (signed two's complement).
- MAX_DIM, 4, largest supported matrix dimension. Packed output width is MAX_DIM*MAX_DIM*DATA_W = 128.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a load; sampled only in IDLE.
- size  in  2  matrix size: 00 = 2x2, 01 = 3x3, 10 = 4x4, 11 = illegal.
- abort  in  1  synchronous cancel; returns the block to IDLE.
- in_data  in  8  signed element, row-major order.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts an element this cycle.
- A  out  128  packed matrix, element (r,c) at grid index r*4+c.
- a_valid  out  1  A is complete and stable.
- a_ready  in  1  consumer accepts A.
- busy  out  1  state is not IDLE.
- err  out  1  one-cycle pulse on start with size=11.

Behaviour:
- Reset (async, rst=1): state=IDLE; A=0, a_valid=0, in_ready=0, busy=0, err=0; row/col counters 0. All outputs are registered.
- FSM states: IDLE, LOAD, HOLD.
- IDLE:
  - start=1 with legal size: latch n (2/3/4), clear A to 0, row=col=0, go to LOAD. in_ready=1 and busy=1 from the next cycle.
  - start=1 with size=11: err=1 for exactly the next cycle; stay in IDLE; A unchanged.
- LOAD:
  - in_ready=1.
  - On in_valid & in_ready: write in_data to grid index row*4+col.
  - Column advances 0..n-1, then wraps to 0 and row increments.
  - Cycles with in_valid=0 leave counters and A unchanged. Gaps are unlimited.
  - Accepting element (n-1, n-1) moves to HOLD. Next cycle: in_ready=0, a_valid=1.
  - Latency: a_valid rises one cycle after the last input handshake.
- HOLD:
  - a_valid=1; A frozen; in_ready=0; in_data ignored.
  - On a_valid & a_ready: next cycle a_valid=0, go to IDLE, busy=0. A retains its value until the next start.
  - A consumer holding a_ready high completes the transfer in one cycle.
- Grid positions outside the n x n top-left block are always 0. For example, 2x2 uses grid indices 0, 1, 4, 5.
- start while busy: ignored. size changes during LOAD or HOLD: ignored; the latched n is used.
- abort=1 in any state: next cycle state=IDLE, A=0, a_valid=0, in_ready=0, counters 0.
  - abort has priority over start, input handshake and output handshake in the same cycle.
  - abort in IDLE only clears A.
- Reset asserted mid-load: immediate return to reset values. No partial matrix is ever flagged valid.
- The element counter never exceeds n*n-1. No input is accepted in HOLD, so no overrun is possible.

Decomposition:
- Shared package matrix_pkg holds:
  - DATA_W and MAX_DIM constants.
  - Size encodings SIZE_2X2 = 2'b00, SIZE_3X3 = 2'b01, SIZE_4X4 = 2'b10.
  - The loader state enum.
  - Function pack_index(row, col), returning bit offset (15-(row*4+col))*8.
  - These items are shared with det_4x4 and future matrix blocks.
- One natural sub-module: matrix_index_counter, a row/col counter with a dimension input, increment enable, clear, and a last flag.

Test Plan:
- 4x4 identity: start, size=10, 16 elements 1,0,0,0,0,1,... with in_valid always high → after the 16th handshake, a_valid=1 next cycle and A=128'h01000000_00010000_00000100_00000001. Feeding det_4x4 yields det=1, overflow=0.
- 2x2 [1,2;3,4]: start, size=00, four elements → A=128'h01020000_03040000_00000000_00000000, a_valid after the 4th handshake.
- 3x3 with in_valid gaps: elements 1..9, in_valid low for 2 cycles between elements; a_ready held low 5 cycles after a_valid.
  - Expected A: bytes 01 02 03 00 / 04 05 06 00 / 07 08 09 00 / 00 00 00 00.
  - A and a_valid stay stable for all 5 cycles; IDLE and busy=0 one cycle after a_ready=1.
- Illegal size: start with size=11 → err=1 for exactly one cycle, busy stays 0, in_ready stays 0.
- Abort after 7 of 16 elements in a 4x4 load → next cycle IDLE, A=0, in_ready=0, a_valid never asserted. A following full 4x4 load completes correctly.
- Async reset asserted in HOLD with a_valid=1 → a_valid=0 and A=0 immediately, without waiting for a clock edge.
